// File: rtl/bill_dispenser_if.sv
// Purpose: groups the dispense request, the note-feed handshake and the status signals of bill_dispenser.
// Latency: none; this is wiring only.
// Backpressure: bill_ready from the note feed holds the offered bill in place.
interface bill_dispenser_if;
    logic        entregar_dinero;
    logic [31:0] monto;
    logic        bill_ready;
    logic        bill_valid;
    logic [1:0]  bill_denom;
    logic [7:0]  bill_count;
    logic        busy;
    logic        done;
    logic        error;

    // Requesting side: the transaction controller plus the note-feed mechanism.
    modport master (
        output entregar_dinero,
        output monto,
        output bill_ready,
        input  bill_valid,
        input  bill_denom,
        input  bill_count,
        input  busy,
        input  done,
        input  error
    );

    // Dispensing side: the bill_dispenser itself.
    modport slave (
        input  entregar_dinero,
        input  monto,
        input  bill_ready,
        output bill_valid,
        output bill_denom,
        output bill_count,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/bill_dispenser.sv
// Purpose: splits a requested amount greedily into four denominations and issues one bill per handshake.
// Latency: a dry pass of N+1 cycles for N bills, then at least one cycle per bill, then a one-cycle done or error pulse.
// Backpressure: bill_ready low holds the offered bill and its code stable; requests are ignored while busy.
module bill_dispenser #(
    parameter logic [31:0] D3        = 32'd20000,
    parameter logic [31:0] D2        = 32'd10000,
    parameter logic [31:0] D1        = 32'd5000,
    parameter logic [31:0] D0        = 32'd1000,
    parameter int unsigned MAX_BILLS = 64
) (
    input  logic            clk,
    input  logic            reset,
    bill_dispenser_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BILLS);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] amt;
    logic [31:0] amt_nxt;
    logic [31:0] rem;
    logic [31:0] rem_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;

    logic [1:0]  pick_code;
    logic [31:0] pick_val;
    logic [31:0] rem_after;
    logic [7:0]  cnt_inc;

    // Greedy choice: largest denomination not exceeding the remaining amount.
    always_comb begin
        pick_code = 2'd0;
        pick_val  = 32'd0;
        if (rem >= D3) begin
            pick_code = 2'd3;
            pick_val  = D3;
        end else if (rem >= D2) begin
            pick_code = 2'd2;
            pick_val  = D2;
        end else if (rem >= D1) begin
            pick_code = 2'd1;
            pick_val  = D1;
        end else if (rem >= D0) begin
            pick_code = 2'd0;
            pick_val  = D0;
        end
    end

    // pick_val never exceeds rem, so this cannot wrap.
    assign rem_after = rem - pick_val;
    assign cnt_inc   = cnt + 8'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: latched amount, remaining amount and bill counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            amt <= 32'd0;
            rem <= 32'd0;
            cnt <= 8'd0;
        end else begin
            amt <= amt_nxt;
            rem <= rem_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Next-state and datapath update: dry pass in CHECK, real issue in ISSUE.
    always_comb begin
        state_nxt = state;
        amt_nxt   = amt;
        rem_nxt   = rem;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.entregar_dinero) begin
                    amt_nxt   = bus.monto;
                    rem_nxt   = bus.monto;
                    cnt_nxt   = 8'd0;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rem == 32'd0) begin
                    if (cnt == 8'd0) begin
                        // A zero amount is rejected outright.
                        state_nxt = S_ERROR;
                    end else begin
                        // Dry pass proved the amount payable: rewind and issue for real.
                        rem_nxt   = amt;
                        cnt_nxt   = 8'd0;
                        state_nxt = S_ISSUE;
                    end
                end else if (rem < D0) begin
                    state_nxt = S_ERROR;
                end else if (cnt == MAX_CNT) begin
                    state_nxt = S_ERROR;
                end else begin
                    rem_nxt = rem_after;
                    cnt_nxt = cnt_inc;
                end
            end
            S_ISSUE: begin
                if (bus.bill_ready) begin
                    rem_nxt = rem_after;
                    cnt_nxt = cnt_inc;
                    if (rem_after == 32'd0) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                // A rejected request reports zero bills afterwards.
                cnt_nxt   = 8'd0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registers only; the dry-pass count stays hidden.
    assign bus.bill_valid = (state == S_ISSUE);
    assign bus.bill_denom = (state == S_ISSUE) ? pick_code : 2'd0;
    assign bus.bill_count = ((state == S_CHECK) || (state == S_ERROR)) ? 8'd0 : cnt;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.error      = (state == S_ERROR);

endmodule

// File: tb/tb_bill_dispenser.sv
// Purpose: self-checking bench for bill_dispenser using a vector table, hand sequences and random requests.
// Latency: checks dry-pass length, first-bill cycle, done/error cycle and idle return against a greedy model.
// Backpressure: drives bill_ready always-high, stalled or random and checks the offered bill holds.
module tb_bill_dispenser;

    localparam int MAXB = 64;

    typedef struct {
        logic [31:0] monto;
        int          mode;
        bit          noise;
        bit          ok;
        int          n;
        int          lat;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    bill_dispenser_if bus ();

    bill_dispenser #(
        .D3       (32'd20000),
        .D2       (32'd10000),
        .D1       (32'd5000),
        .D0       (32'd1000),
        .MAX_BILLS(MAXB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer division per denomination, largest first.
    function automatic void model(input logic [31:0] m, output bit ok, output int n, output int lat);
        logic [31:0] den [4];
        logic [31:0] r;
        int          k;
        den = '{32'd20000, 32'd10000, 32'd5000, 32'd1000};
        exp_q.delete();
        r = m;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            k = int'(r / den[i]);
            n += k;
            for (int j = 0; j < k; j++) exp_q.push_back(3 - i);
            r = r % den[i];
        end
        ok  = (m != 0) && (r == 0) && (n <= MAXB);
        lat = ok ? n + 2 : ((n < MAXB) ? n : MAXB) + 2;
    endfunction

    // mode 0: ready always high; 1: random ready; 2: ready low for the first three offered cycles.
    task automatic run_txn(input logic [31:0] m, input int mode, input bit noise,
                           input bit exp_ok, input int exp_n, input int exp_lat);
        int c        = 0;
        int vseen    = 0;
        int last_acc = -1;
        bit first    = 1'b1;
        bit fin      = 1'b0;
        bit rdy      = 1'b0;
        @(negedge clk);
        bus.entregar_dinero = 1'b1;
        bus.monto           = m;
        bus.bill_ready      = (mode == 0);
        @(negedge clk);
        c = 1;
        bus.entregar_dinero = 1'b0;
        bus.monto           = $urandom;
        while (!fin && c < 400) begin
            chk("busy", bus.busy, 1);
            if (bus.bill_valid) begin
                vseen++;
                if (first) begin
                    chk("first_valid_cycle", c, exp_lat);
                    first = 1'b0;
                end
                if (!exp_ok) chk("valid_on_reject", bus.bill_valid, 0);
                if (exp_q.size() == 0) chk("extra_bill", bus.bill_valid, 0);
                else chk("denom", bus.bill_denom, exp_q[0]);
            end
            if (bus.done) begin
                chk("done", bus.done, exp_ok);
                chk("done_cycle", c, last_acc);
                chk("bills_left", exp_q.size(), 0);
                chk("count_at_done", bus.bill_count, exp_n);
                fin = 1'b1;
            end
            if (bus.error) begin
                chk("error", bus.error, !exp_ok);
                chk("error_cycle", c, exp_lat);
                fin = 1'b1;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (vseen >= 4);
            endcase
            if (fin) begin
                bus.entregar_dinero = 1'b0;
            end else if (noise) begin
                bus.entregar_dinero = 1'($urandom_range(0, 1));
                bus.monto           = 32'd5000;
            end
            bus.bill_ready = rdy;
            if (bus.bill_valid && rdy && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                last_acc = c + 1;
            end
            @(negedge clk);
            c++;
        end
        chk("finished", fin, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_valid", bus.bill_valid, 0);
        chk("idle_count", bus.bill_count, exp_ok ? exp_n : 0);
        chk("idle_done", bus.done, 0);
        chk("idle_error", bus.error, 0);
        bus.bill_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.bill_valid, 0);
        chk({tag, "_denom"}, bus.bill_denom, 0);
        chk({tag, "_count"}, bus.bill_count, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_error"}, bus.error, 0);
    endtask

    initial begin
        vec_t vecs [12];
        bit   ok;
        int   n;
        int   lat;
        int   sel;
        logic [31:0] m;

        vecs[0]  = '{32'd38000,   0, 1'b0, 1'b1, 6,  8};
        vecs[1]  = '{32'd25000,   2, 1'b0, 1'b1, 2,  4};
        vecs[2]  = '{32'd1500,    0, 1'b0, 1'b0, 0,  3};
        vecs[3]  = '{32'd0,       0, 1'b0, 1'b0, 0,  2};
        vecs[4]  = '{32'd1280000, 0, 1'b0, 1'b1, 64, 66};
        vecs[5]  = '{32'd1300000, 0, 1'b0, 1'b0, 0,  66};
        vecs[6]  = '{32'd20000,   1, 1'b1, 1'b1, 1,  3};
        vecs[7]  = '{32'd10000,   0, 1'b0, 1'b1, 1,  3};
        vecs[8]  = '{32'd999,     0, 1'b0, 1'b0, 0,  2};
        vecs[9]  = '{32'd36000,   1, 1'b0, 1'b1, 4,  6};
        vecs[10] = '{32'd5000,    0, 1'b1, 1'b1, 1,  3};
        vecs[11] = '{32'd1000,    2, 1'b0, 1'b1, 1,  3};

        bus.entregar_dinero = 1'b0;
        bus.monto           = 32'd0;
        bus.bill_ready      = 1'b0;
        reset               = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        foreach (vecs[i]) begin
            model(vecs[i].monto, ok, n, lat);
            run_txn(vecs[i].monto, vecs[i].mode, vecs[i].noise, vecs[i].ok, vecs[i].n, vecs[i].lat);
        end

        // Reset while a bill is offered and stalled.
        @(negedge clk);
        bus.entregar_dinero = 1'b1;
        bus.monto           = 32'd20000;
        bus.bill_ready      = 1'b0;
        @(negedge clk);
        bus.entregar_dinero = 1'b0;
        for (int i = 0; i < 20 && !bus.bill_valid; i++) @(negedge clk);
        chk("rst_setup_valid", bus.bill_valid, 1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b1;
        model(32'd10000, ok, n, lat);
        run_txn(32'd10000, 0, 1'b0, ok, n, lat);

        // Random requests against the greedy model.
        for (int t = 0; t < 25; t++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       m = 32'($urandom_range(0, 120) * 500);
                1:       m = 32'($urandom_range(0, 60) * 1000);
                2:       m = 32'($urandom_range(1250, 1320) * 1000);
                default: m = 32'($urandom_range(0, 300000));
            endcase
            model(m, ok, n, lat);
            run_txn(m, 1, 1'($urandom_range(0, 1)), ok, ok ? n : 0, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
